serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the team's existing 1-bit `fa` full-adder cell. It accepts two operands and a carry-in through a valid/ready handshake. It then feeds one bit per clock, LSB first, into `fa`, holding the carry in a flip-flop between bits. The result is presented through a second valid/ready handshake. It is the sequential stage wrapped directly around `fa`: it produces every input `fa` sees and consumes every `sum`/`cout` it produces.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_if.sv | 45 ++++
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: the controller state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The slave modport is the adder's view; the master modport is the
// requester that supplies operands and collects results.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             busy;

    modport slave (
        input  start_valid,
        input  a_in,
        input  b_in,
        input  cin_in,
        input  done_ready,
        output start_ready,
        output done_valid,
        output sum_out,
        output cout_out,
        output busy
    );

    modport master (
        output start_valid,
        output a_in,
        output b_in,
        output cin_in,
        output done_ready,
        input  start_ready,
        input  done_valid,
        input  sum_out,
        input  cout_out,
        input  busy
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_fa.sv
// Existing 1-bit full-adder cell, used unmodified by the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on a valid/ready handshake,
// feeds one bit per clock (LSB first) through the fa cell with the carry held
// in a flop, then presents {cout_out, sum_out} on a second handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    // A 1-bit counter is still needed when WIDTH is 1.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   s_sr_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               cout_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   s_next_s;

    fa u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Sum shift register after this bit: new sum bit enters at the MSB.
    // Written as shift/OR so it also elaborates cleanly for WIDTH == 1.
    always_comb begin
        s_next_s = (s_sr_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
    end

    // Controller FSM together with the operand/sum shift registers, carry
    // flop, bit counter and result registers it sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            s_sr_r  <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // start_ready is high throughout IDLE, so start_valid
                    // alone completes the handshake here.
                    if (bus.start_valid) begin
                        a_sr_r  <= bus.a_in;
                        b_sr_r  <= bus.b_in;
                        carry_r <= bus.cin_in;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    a_sr_r  <= a_sr_r >> 1;
                    b_sr_r  <= b_sr_r >> 1;
                    s_sr_r  <= s_next_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    // Last bit: publish the result on the same edge so the
                    // outputs never show a partially accumulated sum.
                    if (cnt_r == CNT_LAST) begin
                        sum_r   <= s_next_s;
                        cout_r  <= fa_cout_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= ADD;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Handshake/status flags are pure decodes of the state register.
    assign bus.start_ready = (state_r == IDLE);
    assign bus.done_valid  = (state_r == DONE);
    assign bus.busy        = (state_r == ADD) || (state_r == DONE);
    assign bus.sum_out     = sum_r;
    assign bus.cout_out    = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Issue one operation on the 8-bit DUT; returns edges from accept to done_valid.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int lat);
        int n;
        bus8.a_in = a; bus8.b_in = b; bus8.cin_in = c; bus8.start_valid = 1'b1;
        n = 0;
        while (bus8.start_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus8.start_valid = 1'b0;
        bus8.a_in = ~a; bus8.b_in = ~b; bus8.cin_in = ~c;
        lat = 0;
        while (bus8.done_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release8();
        bus8.done_ready = 1'b1;
        @(posedge clk); #1;
        bus8.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus8.start_ready, bus8.done_valid, bus8.busy} !== 3'b100) begin
            $display("FAIL reset_flags got %b want 100", {bus8.start_ready, bus8.done_valid, bus8.busy});
        end else passed++;
        total++;
        if ({bus8.cout_out, bus8.sum_out} !== 9'h000) begin
            $display("FAIL reset_result got %h want 000", {bus8.cout_out, bus8.sum_out});
        end else passed++;
        total++;
        if ({bus1.start_ready, bus1.done_valid, bus1.busy, bus1.cout_out, bus1.sum_out} !== 5'b10000) begin
            $display("FAIL reset_w1 got %b want 10000",
                     {bus1.start_ready, bus1.done_valid, bus1.busy, bus1.cout_out, bus1.sum_out});
        end else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [8:0] te [3];
        int lat;
        ta = '{8'h5A, 8'hFF, 8'hFF};
        tb = '{8'h33, 8'h01, 8'hFF};
        tc = '{1'b0, 1'b0, 1'b1};
        te = '{9'h08D, 9'h100, 9'h1FF};
        for (int i = 0; i < 3; i++) begin
            run_op8(ta[i], tb[i], tc[i], lat);
            total++;
            if (lat !== 8) $display("FAIL basic_latency[%0d] got %0d want 8", i, lat);
            else passed++;
            total++;
            if ({bus8.cout_out, bus8.sum_out} !== te[i])
                $display("FAIL basic_result[%0d] got %h want %h", i, {bus8.cout_out, bus8.sum_out}, te[i]);
            else passed++;
            total++;
            if ({bus8.busy, bus8.start_ready} !== 2'b10)
                $display("FAIL basic_done_flags[%0d] got %b want 10", i, {bus8.busy, bus8.start_ready});
            else passed++;
            release8();
            total++;
            if ({bus8.done_valid, bus8.start_ready, bus8.busy} !== 3'b010)
                $display("FAIL basic_to_idle[%0d] got %b want 010", i,
                         {bus8.done_valid, bus8.start_ready, bus8.busy});
            else passed++;
            total++;
            if ({bus8.cout_out, bus8.sum_out} !== te[i])
                $display("FAIL basic_retain[%0d] got %h want %h", i, {bus8.cout_out, bus8.sum_out}, te[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op8(8'h12, 8'h34, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            bus8.start_valid = k[0] ? 1'b0 : 1'b1;
            bus8.a_in = 8'hAA; bus8.b_in = 8'hAA; bus8.cin_in = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({bus8.done_valid, bus8.start_ready, bus8.busy} !== 3'b101)
                $display("FAIL bp_flags[%0d] got %b want 101", k,
                         {bus8.done_valid, bus8.start_ready, bus8.busy});
            else passed++;
            total++;
            if ({bus8.cout_out, bus8.sum_out} !== 9'h046)
                $display("FAIL bp_hold[%0d] got %h want 046", k, {bus8.cout_out, bus8.sum_out});
            else passed++;
        end
        bus8.start_valid = 1'b0;
        release8();
        total++;
        if ({bus8.done_valid, bus8.start_ready, bus8.busy} !== 3'b010)
            $display("FAIL bp_release got %b want 010", {bus8.done_valid, bus8.start_ready, bus8.busy});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus8.busy, bus8.cout_out, bus8.sum_out} !== 10'h046)
            $display("FAIL bp_not_captured got %h want 046", {bus8.busy, bus8.cout_out, bus8.sum_out});
        else passed++;
    endtask

    task automatic test_reset_mid_add();
        int lat;
        logic seen;
        bus8.a_in = 8'h7F; bus8.b_in = 8'h7F; bus8.cin_in = 1'b0; bus8.start_valid = 1'b1;
        @(posedge clk); #1;
        bus8.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus8.busy !== 1'b1) $display("FAIL rst_mid_busy_before got %b want 1", bus8.busy);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({bus8.start_ready, bus8.done_valid, bus8.busy} !== 3'b100)
            $display("FAIL rst_mid_flags got %b want 100", {bus8.start_ready, bus8.done_valid, bus8.busy});
        else passed++;
        total++;
        if ({bus8.cout_out, bus8.sum_out} !== 9'h000)
            $display("FAIL rst_mid_result got %h want 000", {bus8.cout_out, bus8.sum_out});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus8.done_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL rst_mid_no_done got %b want 0", seen);
        else passed++;
        run_op8(8'h10, 8'h20, 1'b0, lat);
        total++;
        if ({bus8.cout_out, bus8.sum_out} !== 9'h030 || lat !== 8)
            $display("FAIL rst_mid_next got %h lat %0d want 030 lat 8", {bus8.cout_out, bus8.sum_out}, lat);
        else passed++;
        release8();
    endtask

    task automatic test_back_to_back();
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        logic       sc [4];
        logic [8:0] se [4];
        int acc [4];
        int idx, res, cyc;
        logic sr_before;
        sa = '{8'h01, 8'h80, 8'hC3, 8'h99};
        sb = '{8'h02, 8'h80, 8'h3C, 8'h66};
        sc = '{1'b0, 1'b1, 1'b0, 1'b1};
        se = '{9'h003, 9'h101, 9'h0FF, 9'h100};
        idx = 0; res = 0; cyc = 0;
        bus8.a_in = sa[0]; bus8.b_in = sb[0]; bus8.cin_in = sc[0];
        bus8.start_valid = 1'b1; bus8.done_ready = 1'b1;
        while ((idx < 4 || res < 4) && cyc < 100) begin
            sr_before = bus8.start_ready;
            @(posedge clk); #1; cyc++;
            if (sr_before === 1'b1 && bus8.start_valid === 1'b1) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    bus8.a_in = sa[idx]; bus8.b_in = sb[idx]; bus8.cin_in = sc[idx];
                end else begin
                    bus8.start_valid = 1'b0;
                end
            end
            if (bus8.done_valid === 1'b1 && res < 4) begin
                total++;
                if ({bus8.cout_out, bus8.sum_out} !== se[res])
                    $display("FAIL stream_result[%0d] got %h want %h", res, {bus8.cout_out, bus8.sum_out}, se[res]);
                else passed++;
                res++;
            end
        end
        bus8.start_valid = 1'b0; bus8.done_ready = 1'b0;
        total++;
        if (idx !== 4 || res !== 4) $display("FAIL stream_timeout got acc %0d res %0d want 4 4", idx, res);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            if (i < idx) begin
                total++;
                if (acc[i] - acc[i-1] !== 10)
                    $display("FAIL stream_spacing[%0d] got %0d want 10", i, acc[i] - acc[i-1]);
                else passed++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width1();
        logic [15:0] tt;
        logic [1:0]  exp;
        logic [2:0]  v;
        int lat, n;
        tt = 16'b11_10_10_01_10_01_01_00;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            exp = tt[2*i +: 2];
            bus1.a_in = v[2]; bus1.b_in = v[1]; bus1.cin_in = v[0]; bus1.start_valid = 1'b1;
            n = 0;
            while (bus1.start_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            bus1.start_valid = 1'b0;
            bus1.a_in = ~v[2]; bus1.b_in = ~v[1]; bus1.cin_in = ~v[0];
            lat = 0;
            while (bus1.done_valid !== 1'b1 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            total++;
            if (lat !== 1) $display("FAIL w1_latency[%0d] got %0d want 1", i, lat);
            else passed++;
            total++;
            if ({bus1.cout_out, bus1.sum_out} !== exp)
                $display("FAIL w1_result[%0d] got %b want %b", i, {bus1.cout_out, bus1.sum_out}, exp);
            else passed++;
            bus1.done_ready = 1'b1;
            @(posedge clk); #1;
            bus1.done_ready = 1'b0;
        end
    endtask

    initial begin
        bus8.start_valid = 1'b0; bus8.a_in = 8'h00; bus8.b_in = 8'h00;
        bus8.cin_in = 1'b0; bus8.done_ready = 1'b0;
        bus1.start_valid = 1'b0; bus1.a_in = 1'b0; bus1.b_in = 1'b0;
        bus1.cin_in = 1'b0; bus1.done_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        test_width1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_serial_adder
